// File: rtl/azimuth_pkg.sv
// rtl/azimuth_pkg.sv - shared defaults, word count helper and FSM state type
package azimuth_pkg;

   localparam int unsigned SIZE_DEF    = 3200;
   localparam int unsigned WORD_W_DEF  = 32;
   localparam int unsigned CLK_DIV_DEF = 100;
   localparam int unsigned AZ_W        = 12;

   function automatic int unsigned calc_words(input int unsigned size, input int unsigned word_w);
      return (size + word_w - 1) / word_w;
   endfunction

   typedef enum logic [1:0] {
      ST_IDLE       = 2'd0,
      ST_WAIT_FRAME = 2'd1,
      ST_RUN        = 2'd2
   } state_e;

endpackage

// File: rtl/us_tick_gen.sv
// rtl/us_tick_gen.sv - prescaler producing one tick enable every CLK_DIV cycles
module us_tick_gen #(
   parameter int unsigned CLK_DIV = azimuth_pkg::CLK_DIV_DEF
) (
   input  logic clk_i,
   input  logic rst_n_i,
   input  logic ce_en_i,
   input  logic sync_clr_i,
   output logic us_ce_o
);

   localparam int unsigned CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   logic [CNT_W-1:0] cnt_q;
   logic             wrap;

   assign wrap    = (cnt_q == CNT_W'(CLK_DIV - 1));
   assign us_ce_o = ce_en_i && wrap;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         cnt_q <= '0;
      end else if (sync_clr_i) begin
         cnt_q <= '0;
      end else if (ce_en_i) begin
         cnt_q <= wrap ? '0 : cnt_q + 1'b1;
      end
   end

endmodule

// File: rtl/azimuth_frame_scheduler.sv
// rtl/azimuth_frame_scheduler.sv - shadow frame loader, ARP-synchronous swap and azimuth tracking
module azimuth_frame_scheduler
   import azimuth_pkg::*;
#(
   parameter int unsigned SIZE    = SIZE_DEF,
   parameter int unsigned WORD_W  = WORD_W_DEF,
   parameter int unsigned CLK_DIV = CLK_DIV_DEF
) (
   input  logic              clk_i,
   input  logic              rst_n_i,
   input  logic              en_i,
   input  logic              arp_i,
   input  logic              wr_valid_i,
   input  logic [WORD_W-1:0] wr_data_i,
   output logic              wr_ready_o,
   output logic [SIZE-1:0]   data_o,
   output logic              trig_o,
   output logic              us_ce_o,
   output logic [AZ_W-1:0]   az_index_o,
   output logic              running_o,
   output logic [7:0]        underrun_o
);

   localparam int unsigned WORDS = calc_words(SIZE, WORD_W);
   localparam int unsigned CNT_W = (WORDS > 1) ? $clog2(WORDS) : 1;

   state_e            state_q;
   logic              arp_q;
   logic              trig_q;
   logic              running_q;
   logic              swap_q;
   logic              shadow_full_q;
   logic              shadow_full_d;
   logic              wr_ready_q;
   logic [CNT_W-1:0]  wr_cnt_q;
   logic [SIZE-1:0]   shadow_q;
   logic [SIZE-1:0]   data_q;
   logic [AZ_W-1:0]   az_index_q;
   logic [7:0]        underrun_q;

   logic arp_evt;
   logic armed;
   logic swap;
   logic miss;
   logic wr_fire;
   logic last_word;
   logic us_ce;

   assign arp_evt   = arp_i && !arp_q;
   assign armed     = en_i && (state_q != ST_IDLE) && arp_evt;
   assign swap      = armed && shadow_full_q;
   assign miss      = armed && !shadow_full_q;
   assign wr_fire   = wr_valid_i && wr_ready_q;
   assign last_word = (wr_cnt_q == CNT_W'(WORDS - 1));

   // A frame completing in the same cycle as the ARP edge is not yet swappable.
   always_comb begin
      shadow_full_d = shadow_full_q;
      if (swap) begin
         shadow_full_d = 1'b0;
      end else if (wr_fire && last_word) begin
         shadow_full_d = 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         wr_cnt_q      <= '0;
         shadow_full_q <= 1'b0;
         wr_ready_q    <= 1'b0;
         shadow_q      <= '0;
      end else begin
         shadow_full_q <= shadow_full_d;
         wr_ready_q    <= !shadow_full_d;
         if (wr_fire) begin
            wr_cnt_q <= last_word ? '0 : wr_cnt_q + 1'b1;
            for (int b = 0; b < int'(SIZE); b++) begin
               if (wr_cnt_q == CNT_W'(b / int'(WORD_W))) begin
                  shadow_q[b] <= wr_data_i[b % int'(WORD_W)];
               end
            end
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q    <= ST_IDLE;
         running_q  <= 1'b0;
         trig_q     <= 1'b0;
         swap_q     <= 1'b0;
         arp_q      <= 1'b0;
         underrun_q <= '0;
         data_q     <= '0;
      end else begin
         arp_q  <= arp_i;
         trig_q <= 1'b0;
         swap_q <= swap;
         if (miss && (underrun_q != 8'hFF)) begin
            underrun_q <= underrun_q + 8'd1;
         end
         if (swap) begin
            data_q <= shadow_q;
         end
         if (!en_i) begin
            state_q   <= ST_IDLE;
            running_q <= 1'b0;
         end else begin
            case (state_q)
               ST_IDLE: begin
                  state_q <= ST_WAIT_FRAME;
               end
               ST_WAIT_FRAME: begin
                  if (swap) begin
                     state_q   <= ST_RUN;
                     running_q <= 1'b1;
                     trig_q    <= 1'b1;
                  end
               end
               ST_RUN: begin
                  // Re-arm the generator even when the old frame has to repeat.
                  trig_q <= armed;
               end
               default: begin
                  state_q   <= ST_IDLE;
                  running_q <= 1'b0;
               end
            endcase
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         az_index_q <= '0;
      end else if (swap) begin
         az_index_q <= '0;
      end else if (us_ce) begin
         az_index_q <= (az_index_q == AZ_W'(SIZE - 1)) ? '0 : az_index_q + 1'b1;
      end
   end

   // Clearing on both the swap cycle and the TRIG cycle puts the first tick CLK_DIV after TRIG.
   us_tick_gen #(
      .CLK_DIV (CLK_DIV)
   ) u_tick (
      .clk_i      (clk_i),
      .rst_n_i    (rst_n_i),
      .ce_en_i    (state_q != ST_IDLE),
      .sync_clr_i ((state_q == ST_IDLE) || swap || swap_q),
      .us_ce_o    (us_ce)
   );

   assign wr_ready_o = wr_ready_q;
   assign data_o     = data_q;
   assign trig_o     = trig_q;
   assign us_ce_o    = us_ce;
   assign az_index_o = az_index_q;
   assign running_o  = running_q;
   assign underrun_o = underrun_q;

endmodule

// File: tb/tb_azimuth_frame_scheduler.sv
// tb/tb_azimuth_frame_scheduler.sv - randomized self-checking bench with a frame-level reference model
module tb_azimuth_frame_scheduler;

   localparam int SIZE    = 3190;
   localparam int WORD_W  = 32;
   localparam int DIV     = 5;
   localparam int WORDS   = (SIZE + WORD_W - 1) / WORD_W;
   localparam int LAST_W  = SIZE - (WORDS - 1) * WORD_W;

   logic              clk;
   logic              rst_n;
   logic              en;
   logic              arp;
   logic              wr_valid;
   logic [WORD_W-1:0] wr_data;
   logic              wr_ready_o;
   logic [SIZE-1:0]   data_o;
   logic              trig_o;
   logic              us_ce_o;
   logic [11:0]       az_index_o;
   logic              running_o;
   logic [7:0]        underrun_o;

   azimuth_frame_scheduler #(
      .SIZE    (SIZE),
      .WORD_W  (WORD_W),
      .CLK_DIV (DIV)
   ) dut (
      .clk_i      (clk),
      .rst_n_i    (rst_n),
      .en_i       (en),
      .arp_i      (arp),
      .wr_valid_i (wr_valid),
      .wr_data_i  (wr_data),
      .wr_ready_o (wr_ready_o),
      .data_o     (data_o),
      .trig_o     (trig_o),
      .us_ce_o    (us_ce_o),
      .az_index_o (az_index_o),
      .running_o  (running_o),
      .underrun_o (underrun_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_total = 0;
   int n_bad   = 0;
   int cyc     = 0;
   int trig_seen = 0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] word_of(input logic [SIZE-1:0] v, input int k);
      logic [SIZE-1:0] t;
      t = v >> (k * WORD_W);
      return t[31:0];
   endfunction

   function automatic logic [63:0] fold(input logic [SIZE-1:0] v);
      logic [63:0] f;
      f = '0;
      for (int k = 0; k < WORDS; k++) f = {f[62:0], f[63]} ^ {32'(k), word_of(v, k)};
      return f;
   endfunction

   // Reference model: frame buffers, counts and flags derived from the documented rules.
   logic [SIZE-1:0] m_shadow, m_data;
   bit  m_active, m_loaded, m_full, m_ready, m_arp_prev, m_trig, m_ce, m_fire;
   int  m_words, m_since, m_az, m_under;
   logic [31:0] frame_w [WORDS];

   task automatic model_reset();
      m_shadow = '0; m_data = '0;
      m_active = 0; m_loaded = 0; m_full = 0; m_ready = 0; m_arp_prev = 0;
      m_trig = 0; m_ce = 0; m_fire = 0;
      m_words = 0; m_since = 0; m_az = 0; m_under = 0;
   endtask

   task automatic model_step();
      bit evt, swapped;
      evt = arp && !m_arp_prev;
      m_arp_prev = arp;
      m_fire = wr_valid && m_ready;
      m_trig = 0;
      swapped = 0;
      if (m_ce) m_az = (m_az + 1) % SIZE;
      if (en && m_active && evt) begin
         if (m_full) begin
            m_data = m_shadow; m_full = 0; m_trig = 1; m_loaded = 1; m_az = 0; swapped = 1;
         end else begin
            if (m_under < 255) m_under++;
            if (m_loaded) m_trig = 1;
         end
      end
      if (m_fire) begin
         for (int b = 0; b < WORD_W; b++)
            if (m_words * WORD_W + b < SIZE) m_shadow[m_words * WORD_W + b] = wr_data[b];
         m_words++;
         if (m_words == WORDS) begin m_full = 1; m_words = 0; end
      end
      if (!en) begin
         m_active = 0; m_loaded = 0;
      end else if (!m_active) begin
         m_active = 1; m_since = 1;
      end else if (swapped) begin
         m_since = 0;
      end else begin
         m_since++;
      end
      m_ce = m_active && (m_since > 0) && (m_since % DIV == 0);
      m_ready = !m_full;
   endtask

   task automatic tick();
      @(posedge clk);
      if (rst_n) model_step();
      #1;
      cyc++;
      if (trig_o) trig_seen++;
      check_eq("trig", trig_o, m_trig);
      check_eq("running", running_o, m_active && m_loaded);
      check_eq("wr_ready", wr_ready_o, m_ready);
      check_eq("us_ce", us_ce_o, m_ce);
      check_eq("az_index", az_index_o, m_az);
      check_eq("underrun", underrun_o, m_under);
      if (m_trig || trig_o || (cyc % 32 == 0)) check_eq("data_fold", fold(data_o), fold(m_data));
   endtask

   task automatic write_words(input int n, input bit pat);
      int acc, idx, budget;
      acc = 0; budget = 0;
      while (acc < n && budget < 2000) begin
         idx = m_words;
         wr_valid = ($urandom_range(0, 3) != 0);
         wr_data  = pat ? (32'hA5A5_0000 | 32'(idx)) : $urandom;
         tick();
         if (m_fire) begin frame_w[idx] = wr_data; acc++; end
         budget++;
      end
      wr_valid = 1'b0;
      check_eq("write_accepted", acc, n);
   endtask

   task automatic do_reset();
      logic [SIZE-1:0] zero;
      zero = '0;
      rst_n = 1'b0;
      model_reset();
      #1;
      check_eq("rst_data", fold(data_o), fold(zero));
      check_eq("rst_trig", trig_o, 0);
      check_eq("rst_us_ce", us_ce_o, 0);
      check_eq("rst_az", az_index_o, 0);
      check_eq("rst_running", running_o, 0);
      check_eq("rst_underrun", underrun_o, 0);
      check_eq("rst_wr_ready", wr_ready_o, 0);
      tick(); tick();
      rst_n = 1'b1;
   endtask

   int   n, ces, t0;
   bit   saw;
   logic [11:0] prev_az;
   logic [31:0] last_mask;

   initial begin
      rst_n = 1'b0; en = 1'b0; arp = 1'b0; wr_valid = 1'b0; wr_data = '0;
      last_mask = (LAST_W >= 32) ? 32'hFFFF_FFFF : ((32'd1 << LAST_W) - 32'd1);
      model_reset();
      repeat (3) tick();
      rst_n = 1'b1;
      tick();
      check_eq("ready_after_rst", wr_ready_o, 1);

      // load and swap
      en = 1'b1;
      repeat (2) tick();
      write_words(WORDS, 1'b1);
      tick();
      check_eq("full_not_ready", wr_ready_o, 0);
      arp = 1'b1; tick(); arp = 1'b0;
      check_eq("load_trig", trig_o, 1);
      check_eq("load_running", running_o, 1);
      check_eq("load_w0", word_of(data_o, 0), 32'hA5A5_0000);
      check_eq("load_wlast", word_of(data_o, WORDS - 1), (32'hA5A5_0000 | 32'(WORDS - 1)) & last_mask);
      check_eq("ready_in_trig", wr_ready_o, 1);
      n = 0;
      do begin tick(); n++; end while (!us_ce_o && n < 4 * DIV);
      check_eq("first_ce_gap", n, DIV);
      tick();
      check_eq("az_after_ce", az_index_o, 1);

      // underrun with empty shadow in RUN
      t0 = trig_seen;
      repeat (3) begin
         arp = 1'b1; tick(); arp = 1'b0;
         repeat ($urandom_range(1, 20)) tick();
      end
      check_eq("under3", underrun_o, 3);
      check_eq("under3_trigs", trig_seen - t0, 3);
      check_eq("under3_data", word_of(data_o, 0), 32'hA5A5_0000);

      // final word coincident with ARP edge
      write_words(WORDS - 1, 1'b0);
      wr_valid = 1'b1; wr_data = $urandom; arp = 1'b1;
      frame_w[WORDS - 1] = wr_data;
      tick();
      wr_valid = 1'b0; arp = 1'b0;
      check_eq("coin_under", underrun_o, 4);
      check_eq("coin_no_swap", word_of(data_o, 0), 32'hA5A5_0000);
      tick();
      check_eq("coin_full", wr_ready_o, 0);
      arp = 1'b1; tick(); arp = 1'b0;
      check_eq("coin_trig", trig_o, 1);
      check_eq("coin_w0", word_of(data_o, 0), frame_w[0]);
      check_eq("coin_wlast", word_of(data_o, WORDS - 1), frame_w[WORDS - 1] & last_mask);

      // azimuth wrap with no ARP
      saw = 0; prev_az = az_index_o;
      repeat (SIZE * DIV + 3 * DIV) begin
         tick();
         if (prev_az == 12'(SIZE - 1) && az_index_o == 12'd0) saw = 1;
         prev_az = az_index_o;
      end
      check_eq("az_wrap_seen", saw, 1);

      // disable: ticks stop, ARP edges ignored
      en = 1'b0; tick(); tick();
      check_eq("dis_running", running_o, 0);
      ces = 0;
      repeat (3) begin
         arp = 1'b1; tick(); ces += int'(us_ce_o);
         arp = 1'b0; tick(); ces += int'(us_ce_o);
      end
      repeat (20) begin tick(); ces += int'(us_ce_o); end
      check_eq("dis_no_ce", ces, 0);
      check_eq("dis_under", underrun_o, 4);

      // random traffic including held ARP and EN toggles
      en = 1'b1;
      repeat (3000) begin
         if ($urandom_range(0, 199) == 0) en = !en;
         if ($urandom_range(0, 29) == 0) arp = !arp;
         wr_valid = $urandom_range(0, 1);
         wr_data  = $urandom;
         tick();
      end

      // saturation
      en = 1'b1; wr_valid = 1'b0; arp = 1'b0;
      tick(); tick();
      repeat (300) begin arp = 1'b1; tick(); arp = 1'b0; tick(); end
      check_eq("under_sat", underrun_o, 255);

      // reset mid-write discards the partial frame
      do_reset();
      tick();
      write_words(40, 1'b0);
      do_reset();
      tick();
      write_words(WORDS - 1, 1'b0);
      tick();
      check_eq("ready_after_99", wr_ready_o, 1);
      write_words(1, 1'b0);
      check_eq("full_after_100", wr_ready_o, 0);
      arp = 1'b1; tick(); arp = 1'b0;
      check_eq("post_rst_trig", trig_o, 1);
      check_eq("post_rst_w0", word_of(data_o, 0), frame_w[0]);
      check_eq("post_rst_wlast", word_of(data_o, WORDS - 1), frame_w[WORDS - 1] & last_mask);
      repeat (5) tick();

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
